// File: rtl/piano_pkg.sv
// piano_pkg: note codes, LED bar encoding, sequencer state type and the
// built-in song table shared by song_rom and song_sequencer.
package piano_pkg;

    localparam logic [3:0] NOTE_C5   = 4'd0;
    localparam logic [3:0] NOTE_B    = 4'd1;
    localparam logic [3:0] NOTE_A    = 4'd2;
    localparam logic [3:0] NOTE_G    = 4'd3;
    localparam logic [3:0] NOTE_F    = 4'd4;
    localparam logic [3:0] NOTE_E    = 4'd5;
    localparam logic [3:0] NOTE_D    = 4'd6;
    localparam logic [3:0] NOTE_C4   = 4'd7;
    localparam logic [3:0] NOTE_NONE = 4'd8;

    localparam logic [7:0] LED_OFF = 8'h00;
    localparam logic [7:0] LED_ALL = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PLAY,
        ST_PAUSE
    } seq_state_t;

    // C4 lights Led[0], C5 lights Led[7]; silence is dark, illegal codes light all.
    function automatic logic [7:0] led_pattern(input logic [3:0] code);
        logic [7:0] pat;
        if (code <= NOTE_C4)
            pat = 8'h80 >> code;
        else if (code == NOTE_NONE)
            pat = LED_OFF;
        else
            pat = LED_ALL;
        return pat;
    endfunction

    // Song table, one word per entry: {dur[3:0], note[3:0]}; dur 0 ends a song.
    function automatic logic [7:0] song_word(input int unsigned slot, input int unsigned idx);
        logic [7:0] w;
        w = {4'd0, NOTE_NONE};
        case (slot)
            0: w = {4'((idx % 3) + 1), 4'(idx % 10)};
            1: case (idx)
                   0: w = {4'd2, NOTE_C4};
                   1: w = {4'd1, NOTE_E};
                   default: ;
               endcase
            2: case (idx)
                   0: w = {4'd3, NOTE_E};
                   1: w = {4'd1, NOTE_D};
                   2: w = {4'd2, NOTE_G};
                   3: w = {4'd1, 4'd9};
                   default: ;
               endcase
            3: case (idx)
                   0: w = {4'd3, NOTE_D};
                   1: w = {4'd2, NOTE_D};
                   2: w = {4'd0, NOTE_D};
                   default: ;
               endcase
            default: ;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/song_rom.sv
// song_rom: NUM_SONGS x SONG_DEPTH entry ROM with a registered read port.
// Contents come from the song table in piano_pkg; entry = {dur, note}.
module song_rom
    import piano_pkg::*;
#(
    parameter int NUM_SONGS  = 4,
    parameter int SONG_DEPTH = 128,
    parameter int DUR_W      = 4
) (
    input  logic                                            CLK,
    input  logic [$clog2(NUM_SONGS)+$clog2(SONG_DEPTH)-1:0] addr,
    output logic [DUR_W+3:0]                                data
);

    localparam int POS_W = $clog2(SONG_DEPTH);

    logic [7:0] word;

    // Split the address into slot and entry index and look up the table.
    always_comb word = song_word(int'(addr >> POS_W), int'(addr[POS_W-1:0]));

    // One-cycle read latency.
    always_ff @(posedge CLK) data <= {DUR_W'(word[7:4]), word[3:0]};

endmodule

// File: rtl/song_sequencer.sv
// song_sequencer: plays a song slot from song_rom on the note bus / LED bar,
// stepping on beat_tick, with play/stop/pause/loop controls.
// Optional REST_GAP_EN: silences the final tick of a note that is followed by
// the same note code, so repeated notes are articulated.
module song_sequencer
    import piano_pkg::*;
#(
    parameter int NUM_SONGS  = 4,
    parameter int SONG_DEPTH = 128,
    parameter int DUR_W      = 4,
    parameter int SEL_W      = 2
) (
    input  logic                          CLK,
    input  logic                          RESET_N,
    input  logic                          beat_tick,
    input  logic                          play,
    input  logic                          stop,
    input  logic                          pause,
    input  logic                          loop_en,
    input  logic [SEL_W-1:0]              song_sel,
    output logic [3:0]                    note,
    output logic [7:0]                    Led,
    output logic                          playing,
    output logic                          song_done,
    output logic [$clog2(SONG_DEPTH)-1:0] position
);

    localparam int POS_W = $clog2(SONG_DEPTH);
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(SONG_DEPTH - 1);

    seq_state_t       state, state_n;
    logic             load_ph, load_ph_n;
    logic [SEL_W-1:0] sel_q, sel_n;
    logic [POS_W-1:0] pos_n, rd_pos;
    logic             wrapped, wrap_n;
    logic [DUR_W-1:0] counter, cnt_n;
    logic [DUR_W-1:0] cur_dur, dur_n;
    logic [3:0]       note_n;
    logic [7:0]       led_n;
    logic             pending, pend_n;
    logic             done_n;
    logic             tick;
    logic [DUR_W+3:0] rom_q;
    logic [DUR_W-1:0] rom_dur;
    logic [3:0]       rom_note;

    assign rom_dur  = rom_q[DUR_W+3:4];
    assign rom_note = rom_q[3:0];
    assign playing  = (state != ST_IDLE);
    assign tick     = beat_tick | pending;

`ifdef REST_GAP_EN
    logic la_ok;

    // While a note plays the ROM is pointed at the next entry for the repeat check.
    always_comb rd_pos = (state == ST_PLAY || state == ST_PAUSE) ? position + 1'b1 : position;

    // rom_q holds the look-ahead entry only from the second PLAY/PAUSE cycle on.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) la_ok <= 1'b0;
        else          la_ok <= (state == ST_PLAY || state == ST_PAUSE);
    end
`else
    // The ROM always reads the current entry.
    always_comb rd_pos = position;
`endif

    song_rom #(
        .NUM_SONGS (NUM_SONGS),
        .SONG_DEPTH(SONG_DEPTH),
        .DUR_W     (DUR_W)
    ) u_rom (
        .CLK (CLK),
        .addr({sel_q, rd_pos}),
        .data(rom_q)
    );

    // State and datapath registers.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= ST_IDLE;
            load_ph   <= 1'b0;
            sel_q     <= '0;
            position  <= '0;
            wrapped   <= 1'b0;
            counter   <= '0;
            cur_dur   <= '0;
            pending   <= 1'b0;
            note      <= NOTE_NONE;
            Led       <= LED_OFF;
            song_done <= 1'b0;
        end else begin
            state     <= state_n;
            load_ph   <= load_ph_n;
            sel_q     <= sel_n;
            position  <= pos_n;
            wrapped   <= wrap_n;
            counter   <= cnt_n;
            cur_dur   <= dur_n;
            pending   <= pend_n;
            note      <= note_n;
            Led       <= led_n;
            song_done <= done_n;
        end
    end

    // Next state and outputs; stop beats play, play beats everything else.
    always_comb begin
        state_n   = state;
        load_ph_n = load_ph;
        sel_n     = sel_q;
        pos_n     = position;
        wrap_n    = wrapped;
        cnt_n     = counter;
        dur_n     = cur_dur;
        pend_n    = 1'b0;
        note_n    = note;
        led_n     = Led;
        done_n    = 1'b0;

        if (stop) begin
            state_n = ST_IDLE;
            note_n  = NOTE_NONE;
            led_n   = LED_OFF;
        end else if (play) begin
            state_n   = ST_LOAD;
            load_ph_n = 1'b0;
            sel_n     = song_sel;
            pos_n     = '0;
            wrap_n    = 1'b0;
        end else begin
            case (state)
                ST_LOAD: begin
                    pend_n = pending | beat_tick;
                    if (!load_ph) begin
                        load_ph_n = 1'b1;
                    end else begin
                        load_ph_n = 1'b0;
                        if (rom_dur == '0 || wrapped) begin
                            if (loop_en) begin
                                pos_n  = '0;
                                wrap_n = 1'b0;
                            end else begin
                                state_n = ST_IDLE;
                                done_n  = 1'b1;
                                note_n  = NOTE_NONE;
                                led_n   = LED_OFF;
                                pend_n  = 1'b0;
                            end
                        end else begin
                            dur_n  = rom_dur;
                            cnt_n  = '0;
                            note_n = rom_note;
                            led_n  = led_pattern(rom_note);
                            if (pause) begin
                                state_n = ST_PAUSE;
                                pend_n  = 1'b0;
                            end else begin
                                state_n = ST_PLAY;
                            end
                        end
                    end
                end
                ST_PLAY: begin
                    if (pause) begin
                        state_n = ST_PAUSE;
                    end else if (tick) begin
                        if (counter + 1'b1 == cur_dur) begin
                            pos_n     = position + 1'b1;
                            wrap_n    = (position == POS_LAST);
                            state_n   = ST_LOAD;
                            load_ph_n = 1'b0;
                        end else begin
                            cnt_n = counter + 1'b1;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (!pause) state_n = ST_PLAY;
                end
                default: ;
            endcase
        end

`ifdef REST_GAP_EN
        // Once the gap is entered note holds NONE, so comparing against note stays safe.
        if (state == ST_PLAY && state_n == ST_PLAY && la_ok &&
            cur_dur > DUR_W'(1) && counter == cur_dur - 1'b1 && rom_note == note) begin
            note_n = NOTE_NONE;
            led_n  = LED_OFF;
        end
`endif
    end

endmodule

// File: doc/song_sequencer.md
Name: song_sequencer

Overview:
- Parametrised successor to the fixed doremi auto-player.
- Plays one of NUM_SONGS songs from an internal ROM. Each ROM entry holds a note and a duration in quarter-beat ticks.
- Supports play, stop, pause and loop controls, and runs on the system clock with a beat-tick enable instead of clocking from the beat.
- Drives the existing note bus and LED bar, so it sits beside the manual keyboard path feeding the tone generator mux.

Parameters:
- NUM_SONGS, 4: number of song slots in the ROM.
- SONG_DEPTH, 128: entries per slot; must be a power of 2.
- DUR_W, 4: duration field width; a duration of 0 is the end-of-song marker.
- SEL_W, 2: width of song_sel, equal to clog2(NUM_SONGS).

Ports:
- CLK  in  1  system clock.
- RESET_N  in  1  asynchronous active-low reset.
- beat_tick  in  1  single-cycle quarter-beat enable, synchronous to CLK; spacing is at least 4 cycles.
- play  in  1  start pulse.
- stop  in  1  stop pulse.
- pause  in  1  level; freezes playback while high.
- loop_en  in  1  level; restart the song at end-of-song.
- song_sel  in  SEL_W  song index, latched on play.
- note  out  4  note code: 0=C5, 1=B, 2=A, 3=G, 4=F, 5=E, 6=D, 7=C4, 8=none.
- Led  out  8  LED bar pattern.
- playing  out  1  high in LOAD, PLAY and PAUSE.
- song_done  out  1  single-cycle pulse at a non-looping end of song.
- position  out  clog2(SONG_DEPTH)  current entry index.

Behaviour:
- Reset (async, RESET_N low): state=IDLE, note=8, Led=0, playing=0, song_done=0, position=0, tick counter=0, pending=0.
- ROM: entry = {dur[DUR_W-1:0], note[3:0]}.
  - Address = sel_latched*SONG_DEPTH + position.
  - Synchronous read, 1-cycle latency.
- IDLE:
  - note=8.
  - play → latch song_sel, position=0, go to LOAD.
- LOAD (2 cycles: address, then data):
  - If dur==0, or position wrapped past SONG_DEPTH-1, this is end-of-song:
    - loop_en=1 → position=0, reload.
    - loop_en=0 → song_done=1 for one cycle, go to IDLE, note=8.
  - Otherwise register note, clear the tick counter, go to PLAY.
  - note and Led keep the previous value during LOAD; no glitch to none.
- PLAY:
  - On each beat_tick, counter++.
  - When counter+1==dur on a tick: position++, go to LOAD.
  - A tick arriving during LOAD sets pending; pending is consumed as a tick on the first PLAY cycle.
- PAUSE:
  - Entered from PLAY or LOAD-complete while pause=1.
  - Counter frozen, ticks ignored, note held.
  - pause=0 → back to PLAY with the counter unchanged.
- stop: from any state → IDLE next cycle, note=8, no song_done.
- play while not in IDLE restarts from position 0 with a freshly latched song_sel.
- Simultaneous events:
  - stop and play in the same cycle → stop wins.
  - End-of-song and play in the same cycle → the restart wins, no song_done.
- Led: registered, updated the same cycle as note.
  - Codes 0–7 → one-hot 1<<(7-code), so C4→Led[0] and C5→Led[7].
  - 8 → 8'h00.
  - 9–15 → 8'hFF.
- Width rules:
  - position wraps modulo SONG_DEPTH, and a wrap counts as end-of-song.
  - The counter is DUR_W bits and never exceeds dur-1.

Optional Feature:
- Macro REST_GAP_EN.
- When defined: when the next entry has the same note code as the current one, the final tick of the current note outputs note=8 and Led=0 for one beat_tick period (articulation gap).
  - Total duration is unchanged.
  - A dur=1 note gets no gap.
- When undefined: repeated notes are played legato with no change on note.

Decomposition:
- Shared package piano_pkg holds:
  - note code constants (C4..C5, NOTE_NONE=8)
  - LED pattern function / constants
  - state encoding for IDLE/LOAD/PLAY/PAUSE
- Sub-module song_rom:
  - parametrised by NUM_SONGS, SONG_DEPTH, DUR_W
  - synchronous read port
  - contents from an init file
- The sequencer FSM, tick counter and Led encoder live in song_sequencer.

Test Plan:
- Reset mid-PLAY (RESET_N low for 1 cycle at any phase) → note=8, Led=0, playing=0 on the same edge, with no song_done.
- Song 1 = {C4 d2, E d1, end}, play, ticks every 5 cycles → note=7 for 2 ticks, then 5 for 1 tick, then song_done pulse, then note=8.
- Same song with loop_en=1 → sequence 7,7,5,7,7,5 repeats and song_done never asserts.
- pause high for 3 ticks during an E d3 note → the note lasts 3 unpaused ticks and position is unchanged while paused.
- stop and play asserted in the same cycle during PLAY → IDLE with note=8; a later play with song_sel=2 starts slot 2 at position 0.
- With REST_GAP_EN, entries {D d3, D d2} → notes 6,6,8,6,8 per tick; without REST_GAP_EN → 6,6,6,6,6.
